branch_predict_ctrl: RTL and testbench

Branch prediction and redirect controller for the 5-stage pipeline CPU. It keeps a table of 2-bit saturating counters indexed by PC bits, predicts direction and target for branches in IF, and compares the prediction with the branch outcome resolved in EX. On a mismatch it raises flush and redirect signals to the PC mux and the pipeline registers. It sits between the IF-stage PC logic and the EX-stage branch-condition logic that produces `Branch_hazard`.

---
 rtl/branch_predict_ctrl.sv | 97 +++++++++
 tb/tb_branch_predict_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// Branch predictor and EX-stage redirect controller (2-bit BHT).
// Optional BP_STATS_EN builds the branch/mispredict statistics counters.
module branch_predict_ctrl #(
   parameter int IDX_W = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IF_PC,
   input  logic [5:0]  IF_OpCode,
   input  logic [15:0] IF_Imm,
   output logic        Predict_taken,
   output logic [31:0] Predict_target,
   input  logic        EX_Valid,
   input  logic [5:0]  ID_EX_OpCode,
   input  logic [31:0] ID_EX_PC,
   input  logic        ID_EX_Pred_taken,
   input  logic [31:0] ID_EX_Target,
   input  logic        Branch_hazard,
   output logic        Mispredict,
   output logic [31:0] Redirect_PC,
   output logic        Flush_IF_ID,
   output logic        Flush_ID_EX,
   output logic [31:0] Branch_count,
   output logic [31:0] Mispredict_count
);

   localparam int ENTRIES = 2 ** IDX_W;

   logic [1:0]       bht [ENTRIES];
   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] ex_idx;
   logic [31:0]      imm_off;
   logic             resolve;

   function automatic logic is_branch(input logic [5:0] op);
      unique case (op)
         6'h01, 6'h04, 6'h05, 6'h06, 6'h07: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   assign if_idx  = IF_PC[IDX_W+1:2];
   assign ex_idx  = ID_EX_PC[IDX_W+1:2];
   assign imm_off = {{14{IF_Imm[15]}}, IF_Imm, 2'b00};

   // IF reads the registered table; a same-cycle EX update is not bypassed.
   assign Predict_taken  = is_branch(IF_OpCode) & bht[if_idx][1];
   assign Predict_target = IF_PC + 32'd4 + imm_off;

   assign resolve    = EX_Valid & is_branch(ID_EX_OpCode);
   assign Mispredict = resolve & (Branch_hazard != ID_EX_Pred_taken);

   always_comb begin
      Redirect_PC = 32'd0;
      if (Mispredict) begin
         if (Branch_hazard) Redirect_PC = ID_EX_Target;
         else               Redirect_PC = ID_EX_PC + 32'd4;
      end
   end

   assign Flush_IF_ID = Mispredict;
   assign Flush_ID_EX = Mispredict;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'd1;
      end else if (resolve) begin
         if (Branch_hazard) begin
            if (bht[ex_idx] != 2'd3) bht[ex_idx] <= bht[ex_idx] + 2'd1;
         end else begin
            if (bht[ex_idx] != 2'd0) bht[ex_idx] <= bht[ex_idx] - 2'd1;
         end
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] br_cnt;
   logic [31:0] mp_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         br_cnt <= 32'd0;
         mp_cnt <= 32'd0;
      end else begin
         if (resolve)    br_cnt <= br_cnt + 32'd1;
         if (Mispredict) mp_cnt <= mp_cnt + 32'd1;
      end
   end

   assign Branch_count     = br_cnt;
   assign Mispredict_count = mp_cnt;
`else
   assign Branch_count     = 32'd0;
   assign Mispredict_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: directed vectors queue
// expectations, a negedge monitor pops and compares.
module tb_branch_predict_ctrl;

   localparam logic [31:0] P = 32'h00400010;
   localparam logic [31:0] T = 32'h00400020;
   localparam logic [31:0] N = 32'h00400014;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] IF_PC = '0;
   logic [5:0]  IF_OpCode = '0;
   logic [15:0] IF_Imm = '0;
   logic        Predict_taken;
   logic [31:0] Predict_target;
   logic        EX_Valid = 1'b0;
   logic [5:0]  ID_EX_OpCode = '0;
   logic [31:0] ID_EX_PC = '0;
   logic        ID_EX_Pred_taken = 1'b0;
   logic [31:0] ID_EX_Target = '0;
   logic        Branch_hazard = 1'b0;
   logic        Mispredict;
   logic [31:0] Redirect_PC;
   logic        Flush_IF_ID;
   logic        Flush_ID_EX;
   logic [31:0] Branch_count;
   logic [31:0] Mispredict_count;

   typedef struct {
      string       nm;
      logic        pt;
      logic [31:0] tg;
      logic        mp;
      logic [31:0] rd;
      logic [31:0] bc;
      logic [31:0] mc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   branch_predict_ctrl #(.IDX_W(4)) dut (
      .clk(clk),
      .reset(reset),
      .IF_PC(IF_PC),
      .IF_OpCode(IF_OpCode),
      .IF_Imm(IF_Imm),
      .Predict_taken(Predict_taken),
      .Predict_target(Predict_target),
      .EX_Valid(EX_Valid),
      .ID_EX_OpCode(ID_EX_OpCode),
      .ID_EX_PC(ID_EX_PC),
      .ID_EX_Pred_taken(ID_EX_Pred_taken),
      .ID_EX_Target(ID_EX_Target),
      .Branch_hazard(Branch_hazard),
      .Mispredict(Mispredict),
      .Redirect_PC(Redirect_PC),
      .Flush_IF_ID(Flush_IF_ID),
      .Flush_ID_EX(Flush_ID_EX),
      .Branch_count(Branch_count),
      .Mispredict_count(Mispredict_count)
   );

   always #5 clk = ~clk;

   // Counters read 0 when the statistics option is not built.
   function automatic logic [31:0] st(input int v);
`ifdef BP_STATS_EN
      return 32'(v);
`else
      return 32'd0;
`endif
   endfunction

   task automatic chk(input string nm, input string f,
                      input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s.%s got %h expected %h", nm, f, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.nm, "pred_taken", 32'(Predict_taken), 32'(e.pt));
         chk(e.nm, "pred_target", Predict_target, e.tg);
         chk(e.nm, "mispredict", 32'(Mispredict), 32'(e.mp));
         chk(e.nm, "redirect", Redirect_PC, e.rd);
         chk(e.nm, "flush_if_id", 32'(Flush_IF_ID), 32'(e.mp));
         chk(e.nm, "flush_id_ex", 32'(Flush_ID_EX), 32'(e.mp));
         chk(e.nm, "branch_cnt", Branch_count, e.bc);
         chk(e.nm, "mispred_cnt", Mispredict_count, e.mc);
      end
   end

   task automatic drive(
      input string nm,
      input logic [31:0] ipc, input logic [5:0] iop, input logic [15:0] iimm,
      input logic exv, input logic [5:0] eop, input logic [31:0] epc,
      input logic ept, input logic [31:0] etg, input logic hz,
      input logic xpt, input logic [31:0] xtg, input logic xmp,
      input logic [31:0] xrd, input int xbc, input int xmc);
      exp_t e;
      @(posedge clk);
      #1;
      IF_PC = ipc;
      IF_OpCode = iop;
      IF_Imm = iimm;
      EX_Valid = exv;
      ID_EX_OpCode = eop;
      ID_EX_PC = epc;
      ID_EX_Pred_taken = ept;
      ID_EX_Target = etg;
      Branch_hazard = hz;
      e.nm = nm;
      e.pt = xpt;
      e.tg = xtg;
      e.mp = xmp;
      e.rd = xrd;
      e.bc = st(xbc);
      e.mc = st(xmc);
      q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      drive("in_reset", P, 6'h04, 16'h3, 0, 6'h04, P, 0, T, 1,
            0, T, 0, 0, 0, 0);
      @(negedge clk);
      #2 reset = 1'b1;
      drive("pred_rst", P, 6'h04, 16'h3, 0, 6'h04, P, 0, T, 1,
            0, T, 0, 0, 0, 0);
      // IF and EX share entry 4: IF sees the pre-update weak-NT value
      drive("mp_taken", P, 6'h04, 16'h3, 1, 6'h04, P, 0, T, 1,
            0, T, 1, T, 0, 0);
      drive("after_tk", P, 6'h04, 16'h3, 0, 6'h04, P, 0, T, 1,
            1, T, 0, 0, 1, 1);
      for (int i = 0; i < 5; i++)
         drive("sat_tk", P, 6'h04, 16'h3, 1, 6'h04, P, 1, T, 1,
               1, T, 0, 0, 1 + i, 1);
      drive("mp_nt", P, 6'h04, 16'h3, 1, 6'h04, P, 1, T, 0,
            1, T, 1, N, 6, 1);
      drive("sat_chk", P, 6'h04, 16'h3, 0, 6'h04, P, 1, T, 0,
            1, T, 0, 0, 7, 2);
      drive("mp_nt2", P, 6'h04, 16'h3, 1, 6'h04, P, 1, T, 0,
            1, T, 1, N, 7, 2);
      drive("nt2_chk", P, 6'h04, 16'h3, 0, 6'h04, P, 1, T, 0,
            0, T, 0, 0, 8, 3);
      drive("bubble", P, 6'h04, 16'h3, 0, 6'h04, P, 0, T, 1,
            0, T, 0, 0, 8, 3);
      drive("non_br", P, 6'h04, 16'h3, 1, 6'h23, P, 0, T, 1,
            0, T, 0, 0, 8, 3);
      drive("nb_chk", P, 6'h04, 16'h3, 0, 6'h04, P, 0, T, 1,
            0, T, 0, 0, 8, 3);
      drive("bne_mp", P, 6'h04, 16'h3, 1, 6'h05, 32'h00400020, 0,
            32'h00400100, 1, 0, T, 1, 32'h00400100, 8, 3);
      drive("if_nonbr", 32'h00400020, 6'h23, 16'hFFFF, 1, 6'h01,
            32'h00400020, 1, 32'h00400100, 1,
            0, 32'h00400020, 0, 0, 9, 4);
      drive("if_blez", 32'h00400020, 6'h06, 16'hFFFF, 1, 6'h07,
            32'h00400024, 0, 32'h00400200, 0,
            1, 32'h00400020, 0, 0, 10, 4);
      drive("neg_imm", 32'h00400024, 6'h07, 16'h8000, 0, 6'h04, P, 0, T, 0,
            0, 32'h003E0028, 0, 0, 11, 4);
      drive("blez_mp", 32'h00400024, 6'h01, 16'h0, 1, 6'h06,
            32'h00400024, 0, 32'h00400030, 1,
            0, 32'h00400028, 1, 32'h00400030, 11, 4);
      drive("from_0", 32'h00400024, 6'h01, 16'h0, 0, 6'h04, P, 0, T, 0,
            0, 32'h00400028, 0, 0, 12, 5);
      drive("tgt_wrap", 32'hFFFFFFF0, 6'h04, 16'h4, 0, 6'h04, P, 0, T, 0,
            0, 32'h00000004, 0, 0, 12, 5);
      drive("rst_mid", P, 6'h04, 16'h3, 1, 6'h04, P, 0, T, 1,
            0, T, 1, T, 12, 5);
      @(negedge clk);
      #2 reset = 1'b0;
      drive("rst_held", P, 6'h04, 16'h3, 0, 6'h04, P, 0, T, 1,
            0, T, 0, 0, 0, 0);
      @(negedge clk);
      #2 reset = 1'b1;
      for (int i = 0; i < 16; i++)
         drive("scan_rst", 32'h00400000 + 32'(4 * i), 6'h04, 16'h3,
               1, 6'h04, 32'h00400000 + 32'(4 * i), 1, T, 1,
               0, 32'h00400010 + 32'(4 * i), 0, 0, i, 0);
      for (int i = 0; i < 16; i++)
         drive("scan_inc", 32'h00400000 + 32'(4 * i), 6'h04, 16'h3,
               0, 6'h04, P, 0, T, 0,
               1, 32'h00400010 + 32'(4 * i), 0, 0, 16, 0);
      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      #1;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
